register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WORD_W, 32, data width of each register and of each read/write data port.
REQ-002 Parameter NREGS, 32, register count; the select width is log2(NREGS) = 5.
REQ-003 Clocking: one clock, CLK; reset nRST is asynchronous and active-low.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 nRST  in  1  asynchronous active-low reset.
REQ-006 wen  in  NREGS  per-register write enables, expected one-hot or zero; bit i targets register i.
REQ-007 wdat  in  WORD_W  write data.
REQ-008 rsel1  in  5  read port 1 register select.
REQ-009 rsel2  in  5  read port 2 register select.
REQ-010 rdat1  out  WORD_W  read port 1 data.
REQ-011 rdat2  out  WORD_W  read port 2 data.
REQ-012 onehot_err  out  1  sticky flag: a multi-hot wen was seen since reset.
REQ-013 wr_cnt  out  16  count of committed writes since reset.

Function
REQ-014 Writes SHALL commit on the rising CLK edge: if wen has exactly one bit i set and i != 0, register i takes wdat.
REQ-015 Register 0 SHALL always read as 0.
- wen[0] alone commits nothing and does not increment wr_cnt.
- wen[0] still counts toward the multi-hot check.
REQ-016 If wen has two or more bits set, no register SHALL change that cycle.
- onehot_err goes to 1 on that edge.
- onehot_err holds 1 until nRST is asserted.
REQ-017 wen == 0 SHALL change no register, wr_cnt or onehot_err.
REQ-018 Reads SHALL be combinational, with zero latency: rdatN = register[rselN].
REQ-019 Write-through bypass SHALL apply: if a write to register k (k != 0) commits at the next edge and rselN == k, rdatN SHALL show wdat in the same cycle.
- No bypass when the write is suppressed by the multi-hot rule.
- No bypass for register 0.
REQ-020 Both read ports SHALL be independent and may select the same register, including the register being written.
REQ-021 wr_cnt SHALL increment by 1 on each committed write.
- It wraps from 0xFFFF to 0x0000 with no flag.
REQ-022 Non-written registers SHALL hold their value indefinitely.

Reset
REQ-023 While nRST = 0, all registers SHALL be 0, wr_cnt 0 and onehot_err 0, regardless of CLK.
REQ-024 Assertion of nRST mid-operation SHALL clear state immediately.
- A write coincident with the reset-release edge is discarded.
- rdat1/rdat2 read 0 throughout reset.

Structure
REQ-025 WORD_W, NREGS, the 5-bit select type and the 32-bit word type SHALL live in the shared CPU types package.
REQ-026 No sub-module is required; the one-hot/multi-hot check MAY be a local function.
- The upstream write-select decoder remains a separate module that drives wen.

Verification
REQ-027 Reset then read: nRST = 0 then release; rsel1 = 5, rsel2 = 31 -> rdat1 = 0, rdat2 = 0, wr_cnt = 0, onehot_err = 0.
REQ-028 Write and readback: wen = 1<<7, wdat = 0xDEADBEEF for one edge, then wen = 0; rsel1 = 7 -> rdat1 = 0xDEADBEEF, wr_cnt = 1.
REQ-029 Register 0 protection: wen = 1<<0, wdat = 0xFFFFFFFF -> rsel1 = 0 reads 0; wr_cnt unchanged.
REQ-030 Bypass: register 3 = 0x11; wen = 1<<3, wdat = 0x22, rsel2 = 3 before the edge -> rdat2 = 0x22 in that same cycle; after the edge, 0x22 persists with wen = 0.
REQ-031 Multi-hot: registers 4 and 9 = 0xA and 0xB; wen = (1<<4)|(1<<9), wdat = 0x55 -> both unchanged, onehot_err = 1 and stays 1 over 10 idle cycles; cleared only by nRST.
REQ-032 Wrap and async reset:
- 65536 writes to register 1 -> wr_cnt = 0.
- Assert nRST between edges -> register 1 reads 0 immediately.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared CPU types for the register file: word and select widths plus the
// matching typedefs used by the register file and its neighbours.
`timescale 1ns/1ps
package register_file_pkg;

  localparam int WORD_W = 32;
  localparam int NREGS  = 32;
  localparam int SEL_W  = $clog2(NREGS);
  localparam int CNT_W  = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NREGS-1:0]  wen_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/register_file.sv
// Two-read, one-write register file with hard-wired zero register, same-cycle
// write-through, multi-hot write protection and a committed-write counter.
`timescale 1ns/1ps
module register_file
  import register_file_pkg::cnt_t;
#(
  parameter int  WORD_W = register_file_pkg::WORD_W,
  parameter int  NREGS  = register_file_pkg::NREGS,
  localparam int SEL_W  = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NREGS-1:0]  wen,
  input  logic [WORD_W-1:0] wdat,
  input  logic [SEL_W-1:0]  rsel1,
  input  logic [SEL_W-1:0]  rsel2,
  output logic [WORD_W-1:0] rdat1,
  output logic [WORD_W-1:0] rdat2,
  output logic              onehot_err,
  output logic [15:0]       wr_cnt
);

  function automatic logic is_multi_hot(logic [NREGS-1:0] v);
    return (v & (v - NREGS'(1))) != '0;
  endfunction

  function automatic logic [SEL_W-1:0] onehot_idx(logic [NREGS-1:0] v);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (v[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  logic [WORD_W-1:0] regs_q [NREGS];
  logic [WORD_W-1:0] regs_d [NREGS];
  cnt_t              wr_cnt_q, wr_cnt_d;
  logic              onehot_err_q, onehot_err_d;
  // Goes high one edge after reset release so a write on that edge is dropped.
  logic              en_q, en_d;

  logic             multi_hot;
  logic [SEL_W-1:0] widx;
  logic             wr_commit;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    regs_d       = regs_q;
    wr_cnt_d     = wr_cnt_q;
    onehot_err_d = onehot_err_q;
    en_d         = 1'b1;

    multi_hot = is_multi_hot(wen);
    widx      = onehot_idx(wen);
    wr_commit = en_q && !multi_hot && (wen != '0) && (widx != '0);

    if (wr_commit) begin
      regs_d[widx] = wdat;
      wr_cnt_d     = wr_cnt_q + cnt_t'(1);
    end
    if (en_q && multi_hot) onehot_err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the storage array is reset too, because reads must return 0 during and after reset.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wr_cnt_q     <= '0;
      onehot_err_q <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs_q       <= regs_d;
      wr_cnt_q     <= wr_cnt_d;
      onehot_err_q <= onehot_err_d;
      en_q         <= en_d;
    end
  end

  // Register 0 is never written, so it reads 0 without a special case on storage.
  assign rdat1 = (rsel1 == '0)                ? '0   :
                 (wr_commit && widx == rsel1) ? wdat : regs_q[rsel1];
  assign rdat2 = (rsel2 == '0)                ? '0   :
                 (wr_commit && widx == rsel2) ? wdat : regs_q[rsel2];

  assign wr_cnt     = wr_cnt_q;
  assign onehot_err = onehot_err_q;

endmodule
